// File: rtl/token_pos_streamer.sv
// Adds the positional table to a captured 15-token frame and streams it one saturated Q4.4 row per cycle, cls first.
// First row valid one cycle after tok_in_valid; a stalled row holds until out_ready, and out_ready only feeds registers.
module token_pos_streamer #(
  parameter int DW      = 8,
  parameter int EMB_DIM = 16,
  parameter int NUM_TOK = 15
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [0:15][0:EMB_DIM-1][DW-1:0]         tok_in,
  input  logic                                     tok_in_valid,
  input  logic [0:NUM_TOK-1][0:EMB_DIM-1][DW-1:0]  pos_emb,
  output logic                                     busy,
  output logic [0:EMB_DIM-1][DW-1:0]               out_row,
  output logic [3:0]                               out_idx,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_last,
  output logic                                     frame_done,
  output logic                                     overrun,
  output logic                                     overrun_err
);

  typedef logic [0:EMB_DIM-1][DW-1:0] row_t;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_TOK - 1);

  state_t                                   state;
  logic [0:NUM_TOK-1][0:EMB_DIM-1][DW-1:0]  tok_buf;
  logic [3:0]                               nxt_idx;
  logic                                     unused_rows;

  // Rows past the last token carry nothing we emit.
  assign unused_rows = ^tok_in[NUM_TOK:15];
  assign nxt_idx     = out_idx + 4'd1;
  assign busy        = (state != IDLE);

  // Sign-extended add; overflow shows up as the top two sum bits disagreeing.
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      return {s[DW], {(DW-1){~s[DW]}}};
    return s[DW-1:0];
  endfunction

  function automatic row_t add_row(input row_t a, input row_t b);
    row_t r;
    for (int e = 0; e < EMB_DIM; e++)
      r[e] = sat_add(a[e], b[e]);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tok_buf     <= '0;
      out_row     <= '0;
      out_idx     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (tok_in_valid) begin
            for (int t = 0; t < NUM_TOK; t++)
              tok_buf[t] <= tok_in[t];
            // Output index 0 is the cls row, stored last in the input matrix.
            out_row   <= add_row(tok_in[NUM_TOK-1], pos_emb[0]);
            out_idx   <= '0;
            out_valid <= 1'b1;
            out_last  <= (LAST_IDX == 4'd0);
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (tok_in_valid) begin
            overrun     <= 1'b1;
            overrun_err <= 1'b1;
          end
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              out_idx    <= '0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              // Output t >= 1 comes from input row t-1, i.e. buffer row out_idx.
              out_row  <= add_row(tok_buf[out_idx], pos_emb[nxt_idx]);
              out_idx  <= nxt_idx;
              out_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          if (tok_in_valid) begin
            overrun     <= 1'b1;
            overrun_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_token_pos_streamer.sv
// Directed frames with a queue scoreboard of expected rows, checked at the falling edge.
module tb_token_pos_streamer;

  typedef logic [0:15][7:0] row_t;
  typedef struct {
    row_t       row;
    logic [3:0] idx;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [0:15][0:15][7:0]   tok_in;
  logic                     tok_in_valid;
  logic [0:14][0:15][7:0]   pos_emb;
  logic                     busy;
  row_t                     out_row;
  logic [3:0]               out_idx;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     frame_done;
  logic                     overrun;
  logic                     overrun_err;

  logic [0:15][0:15][7:0]   tok;
  logic [0:14][0:15][7:0]   pos;
  exp_t                     exp_q[$];
  int                       vectors = 0;
  int                       miscompares = 0;
  int                       cyc = 0;
  int                       t0 = 0;

  token_pos_streamer #(.DW(8), .EMB_DIM(16), .NUM_TOK(15)) dut (
    .clk(clk), .rst(rst), .tok_in(tok_in), .tok_in_valid(tok_in_valid),
    .pos_emb(pos_emb), .busy(busy), .out_row(out_row), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done), .overrun(overrun), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_sat(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  // Drive one frame pulse and queue the 15 rows the consumer must see.
  task automatic load_frame();
    exp_t e;
    int   src;
    tok_in = tok;
    pos_emb = pos;
    tok_in_valid = 1'b1;
    for (int t = 0; t < 15; t++) begin
      src = (t == 0) ? 14 : t - 1;
      for (int l = 0; l < 16; l++)
        e.row[l] = ref_sat(tok[src][l], pos[t][l]);
      e.idx = 4'(t);
      exp_q.push_back(e);
    end
    t0 = cyc;
    @(negedge clk);
    tok_in_valid = 1'b0;
    check("first_valid", 128'(out_valid), 128'(1));
    check("first_idx", 128'(out_idx), 128'(0));
    check("busy_after_load", 128'(busy), 128'(1));
  endtask

  task automatic stream_frame(input bit bp, input int ovr_at);
    exp_t       e;
    bit         done = 0;
    bit         have_hold = 0;
    bit         ovr_done = 0;
    bit         ovr_chk = 0;
    bit         ovr_after = 0;
    row_t       hold_row = '0;
    logic [3:0] hold_idx = '0;
    logic [0:15][0:15][7:0] tok_save;
    int         cycles = 0;
    tok_save = tok_in;
    while (!done && cycles < 500) begin
      if (ovr_after) begin
        check("overrun_one_cycle", 128'(overrun), 128'(0));
        ovr_after = 0;
      end
      if (ovr_chk) begin
        check("overrun_pulse", 128'(overrun), 128'(1));
        check("overrun_err_set", 128'(overrun_err), 128'(1));
        tok_in_valid = 1'b0;
        tok_in = tok_save;
        ovr_chk = 0;
        ovr_after = 1;
      end
      if (have_hold) begin
        check("hold_row", 128'(out_row), 128'(hold_row));
        check("hold_idx", 128'(out_idx), 128'(hold_idx));
      end
      if (!out_valid) begin
        check("valid_in_stream", 128'(out_valid), 128'(1));
        break;
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ovr_at >= 0 && !ovr_done && out_idx == 4'(ovr_at)) begin
        tok_in = ~tok_save;
        tok_in_valid = 1'b1;
        ovr_done = 1;
        ovr_chk = 1;
      end
      if (out_ready) begin
        have_hold = 0;
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 128'(1), 128'(0));
          break;
        end
        e = exp_q.pop_front();
        check("row", 128'(out_row), 128'(e.row));
        check("idx", 128'(out_idx), 128'(e.idx));
        check("last", 128'(out_last), 128'(e.idx == 4'd14));
        if (e.idx == 4'd14) done = 1;
      end else begin
        have_hold = 1;
        hold_row = out_row;
        hold_idx = out_idx;
      end
      @(negedge clk);
      cycles++;
    end
    if (!done) check("stream_timeout", 128'(0), 128'(1));
    out_ready = 1'b1;
    check("frame_done", 128'(frame_done), 128'(1));
    check("valid_after_last", 128'(out_valid), 128'(0));
    check("idx_after_last", 128'(out_idx), 128'(0));
    check("busy_in_done", 128'(busy), 128'(1));
    @(negedge clk);
    check("frame_done_pulse", 128'(frame_done), 128'(0));
    check("busy_idle", 128'(busy), 128'(0));
    if (!bp && ovr_at < 0) check("idle_latency", 128'(cyc - t0), 128'(17));
  endtask

  initial begin
    rst = 1'b1;
    tok_in_valid = 1'b0;
    out_ready = 1'b1;
    tok_in = '0;
    pos_emb = '0;
    tok = '0;
    pos = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_row", 128'(out_row), 128'(0));
    check("rst_idx", 128'(out_idx), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_flags", 128'({out_last, frame_done, overrun, overrun_err}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic frame: patches 1.0, cls 0.5, position 0.25; row 15 must be ignored.
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++)
        tok[r][l] = (r < 14) ? 8'h10 : (r == 14 ? 8'h08 : 8'hAA);
    for (int t = 0; t < 15; t++)
      for (int l = 0; l < 16; l++)
        pos[t][l] = 8'h04;
    load_frame();
    check("basic_tok0", 128'(out_row[0]), 128'(8'h0C));
    stream_frame(1'b0, -1);

    // Saturation in both directions plus a lane that cancels to zero.
    tok[0] = {16{8'h70}};
    pos[1] = {16{8'h20}};
    tok[1] = {16{8'h90}};
    pos[2] = {16{8'hE0}};
    tok[2][3] = 8'h7F;
    pos[3][3] = 8'h81;
    load_frame();
    stream_frame(1'b0, -1);

    // Random data under random backpressure.
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++)
        tok[r][l] = 8'($urandom);
    for (int t = 0; t < 15; t++)
      for (int l = 0; l < 16; l++)
        pos[t][l] = 8'($urandom);
    load_frame();
    stream_frame(1'b1, -1);

    // Overrun mid-frame, then an IDLE load that must still be accepted.
    load_frame();
    stream_frame(1'b0, 5);
    load_frame();
    check("overrun_err_sticky", 128'(overrun_err), 128'(1));
    stream_frame(1'b1, -1);

    // Reset at token 7 drops the frame.
    load_frame();
    for (int i = 0; i < 20 && out_idx != 4'd7; i++) @(negedge clk);
    check("reached_idx7", 128'(out_idx), 128'(7));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("rst_mid_valid", 128'(out_valid), 128'(0));
    check("rst_mid_busy", 128'(busy), 128'(0));
    check("rst_mid_err", 128'(overrun_err), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", 128'({frame_done, out_valid}), 128'(0));
    end

    // Fresh frame after reset, then a second one on the first IDLE cycle.
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++)
        tok[r][l] = 8'(r * 16 + l);
    load_frame();
    stream_frame(1'b0, -1);
    load_frame();
    check("b2b_no_overrun", 128'({overrun, overrun_err}), 128'(0));
    stream_frame(1'b1, -1);
    check("b2b_no_overrun_end", 128'(overrun_err), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
